// File: rtl/alu_65c02_pkg.sv
// rtl/alu_65c02_pkg.sv - shared types and helpers for the 65C02 ALU sequencer
// Contents: alu_op_t operation codes, alu_state_t sequencer states,
// op_writes_a() which tells whether an operation's result goes back to A.
package alu_65c02_pkg;

  typedef enum logic [3:0] {
    OP_ADC = 4'd0,
    OP_SBC = 4'd1,
    OP_AND = 4'd2,
    OP_ORA = 4'd3,
    OP_EOR = 4'd4,
    OP_ASL = 4'd5,
    OP_LSR = 4'd6,
    OP_ROL = 4'd7,
    OP_ROR = 4'd8,
    OP_INC = 4'd9,
    OP_DEC = 4'd10,
    OP_CMP = 4'd11,
    OP_BIT = 4'd12
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DADJ = 2'd2,
    ST_DONE = 2'd3
  } alu_state_t;

  // CMP, BIT and the undefined codes (13..15) never update A.
  function automatic logic op_writes_a(input logic [3:0] op);
    return (op <= 4'(OP_DEC));
  endfunction

endpackage

// File: rtl/bcd_adjust.sv
// rtl/bcd_adjust.sv - decimal correction of a binary ADC/SBC result
// Ports:
//   bin_r  in  8  binary result
//   bin_c  in  1  binary carry out (no-borrow for subtract)
//   nib_c  in  1  carry out of the low nibble (no-borrow for subtract)
//   sub    in  1  1 = SBC correction, 0 = ADC correction
//   bcd_r  out 8  corrected result
//   bcd_c  out 1  decimal carry (no-borrow for subtract)
module bcd_adjust (
  input  logic [7:0] bin_r,
  input  logic       bin_c,
  input  logic       nib_c,
  input  logic       sub,
  output logic [7:0] bcd_r,
  output logic       bcd_c
);

  logic       lo_adj;
  logic       hi_adj;
  logic [8:0] sum1;

  always_comb begin
    lo_adj = 1'b0;
    hi_adj = 1'b0;
    sum1   = {bin_c, bin_r};
    bcd_r  = bin_r;
    bcd_c  = bin_c;
    if (sub) begin
      bcd_r = bin_r - (nib_c ? 8'h00 : 8'h06) - (bin_c ? 8'h00 : 8'h60);
      bcd_c = bin_c;
    end else begin
      // The +6 on the low nibble ripples into the high nibble exactly when
      // the decimal low digit overflowed without a binary half carry.
      lo_adj = nib_c || (bin_r[3:0] > 4'd9);
      sum1   = {bin_c, bin_r} + (lo_adj ? 9'h006 : 9'h000);
      hi_adj = (sum1[8:4] > 5'd9);
      bcd_r  = sum1[7:0] + (hi_adj ? 8'h60 : 8'h00);
      bcd_c  = hi_adj;
    end
  end

endmodule

// File: rtl/alu_sequencer_65c02.sv
// rtl/alu_sequencer_65c02.sv - multi-cycle 65C02 ALU stage feeding the accumulator
// Ports:
//   fclk, reset                  clock, synchronous active-high reset
//   start, op, decimal           request, alu_op_t code, D flag
//   a_in, b_in, carry_in         operands and current C flag
//   busy, result_valid           sequencer status, one-cycle done pulse
//   alu_out                      result, held until next accepted start
//   alu_to_accumulator_xfer      accumulator write strobe
//   n_out, v_out, z_out, c_out   flag results, held with alu_out
module alu_sequencer_65c02
  import alu_65c02_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             fclk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             decimal,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_to_accumulator_xfer,
  output logic             n_out,
  output logic             v_out,
  output logic             z_out,
  output logic             c_out
);

  alu_state_t state;
  logic [3:0] op_q;
  logic       dec_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic       cin_q;

  logic [7:0] b_eff;
  logic       cy_sel;
  logic [8:0] sum9;
  logic [4:0] lo5;
  logic [7:0] r_n;
  logic       n_n, v_n, z_n, c_n;
  logic [7:0] bcd_r;
  logic       bcd_c;

  // SBC and CMP share the adder with B complemented; CMP forces carry-in.
  always_comb begin
    b_eff  = (op_q == OP_ADC) ? b_q : ~b_q;
    cy_sel = (op_q == OP_CMP) ? 1'b1 : cin_q;
    sum9   = {1'b0, a_q} + {1'b0, b_eff} + {8'd0, cy_sel};
    lo5    = {1'b0, a_q[3:0]} + {1'b0, b_eff[3:0]} + {4'd0, cy_sel};
    r_n    = a_q;
    n_n    = 1'b0;
    v_n    = 1'b0;
    z_n    = 1'b0;
    c_n    = cin_q;
    case (op_q)
      OP_ADC, OP_SBC: begin
        r_n = sum9[7:0];
        c_n = sum9[8];
        v_n = (a_q[7] == b_eff[7]) && (sum9[7] != a_q[7]);
      end
      OP_AND: r_n = a_q & b_q;
      OP_ORA: r_n = a_q | b_q;
      OP_EOR: r_n = a_q ^ b_q;
      OP_ASL: begin r_n = {a_q[6:0], 1'b0};  c_n = a_q[7]; end
      OP_LSR: begin r_n = {1'b0, a_q[7:1]};  c_n = a_q[0]; end
      OP_ROL: begin r_n = {a_q[6:0], cin_q}; c_n = a_q[7]; end
      OP_ROR: begin r_n = {cin_q, a_q[7:1]}; c_n = a_q[0]; end
      OP_INC: r_n = a_q + 8'd1;
      OP_DEC: r_n = a_q - 8'd1;
      OP_CMP: begin r_n = sum9[7:0]; c_n = sum9[8]; end
      OP_BIT: begin
        n_n = b_q[7];
        v_n = b_q[6];
        z_n = ((a_q & b_q) == 8'd0);
      end
      default: ;
    endcase
    // Every defined op except BIT takes N/Z from its own result.
    if (op_q <= 4'(OP_CMP)) begin
      n_n = r_n[7];
      z_n = (r_n == 8'd0);
    end
  end

  // alu_out/c_out hold the binary result while in DADJ; lo5 is recomputed
  // from the still-latched operands, so no half-carry register is needed.
  bcd_adjust u_bcd_adjust (
    .bin_r (alu_out),
    .bin_c (c_out),
    .nib_c (lo5[4]),
    .sub   (op_q == OP_SBC),
    .bcd_r (bcd_r),
    .bcd_c (bcd_c)
  );

  always_ff @(posedge fclk) begin
    if (reset) begin
      state                   <= ST_IDLE;
      op_q                    <= 4'd0;
      dec_q                   <= 1'b0;
      a_q                     <= 8'd0;
      b_q                     <= 8'd0;
      cin_q                   <= 1'b0;
      alu_out                 <= 8'd0;
      n_out                   <= 1'b0;
      v_out                   <= 1'b0;
      z_out                   <= 1'b0;
      c_out                   <= 1'b0;
      busy                    <= 1'b0;
      result_valid            <= 1'b0;
      alu_to_accumulator_xfer <= 1'b0;
    end else begin
      result_valid            <= 1'b0;
      alu_to_accumulator_xfer <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q  <= op;
            dec_q <= decimal;
            a_q   <= a_in;
            b_q   <= b_in;
            cin_q <= carry_in;
            busy  <= 1'b1;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          alu_out <= r_n;
          n_out   <= n_n;
          v_out   <= v_n;
          z_out   <= z_n;
          c_out   <= c_n;
          if (dec_q && (op_q == OP_ADC || op_q == OP_SBC)) begin
            state <= ST_DADJ;
          end else begin
            state                   <= ST_DONE;
            result_valid            <= 1'b1;
            alu_to_accumulator_xfer <= op_writes_a(op_q);
          end
        end
        ST_DADJ: begin
          alu_out                 <= bcd_r;
          c_out                   <= bcd_c;
          n_out                   <= bcd_r[7];
          z_out                   <= (bcd_r == 8'd0);
          state                   <= ST_DONE;
          result_valid            <= 1'b1;
          alu_to_accumulator_xfer <= op_writes_a(op_q);
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer_65c02.sv
// tb/tb_alu_sequencer_65c02.sv - directed self-checking bench for alu_sequencer_65c02
module tb_alu_sequencer_65c02;
  import alu_65c02_pkg::*;

  logic       fclk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] op;
  logic       decimal;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       carry_in;
  logic       busy;
  logic       result_valid;
  logic [7:0] alu_out;
  logic       alu_to_accumulator_xfer;
  logic       n_out, v_out, z_out, c_out;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses;

  always #5 fclk = ~fclk;

  alu_sequencer_65c02 #(.WIDTH(8)) dut (
    .fclk                    (fclk),
    .reset                   (reset),
    .start                   (start),
    .op                      (op),
    .decimal                 (decimal),
    .a_in                    (a_in),
    .b_in                    (b_in),
    .carry_in                (carry_in),
    .busy                    (busy),
    .result_valid            (result_valid),
    .alu_out                 (alu_out),
    .alu_to_accumulator_xfer (alu_to_accumulator_xfer),
    .n_out                   (n_out),
    .v_out                   (v_out),
    .z_out                   (z_out),
    .c_out                   (c_out)
  );

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic d, input logic [7:0] a,
                       input logic [7:0] b, input logic c);
    op = o; decimal = d; a_in = a; b_in = b; carry_in = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Flags compared as {N,V,Z,C} under a mask.
  task automatic run_op(input string tag, input logic [3:0] o, input logic d,
                        input logic [7:0] a, input logic [7:0] b, input logic c,
                        input int exp_cyc, input logic [7:0] exp_out,
                        input logic [3:0] exp_f, input logic [3:0] mask,
                        input logic exp_x);
    int cyc;
    issue(o, d, a, b, c);
    check({tag, " busy"}, 32'(busy), 32'd1);
    cyc = 1;
    while (!result_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
    check({tag, " alu_out"}, 32'(alu_out), 32'(exp_out));
    check({tag, " flags"}, 32'({n_out, v_out, z_out, c_out} & mask), 32'(exp_f & mask));
    check({tag, " xfer"}, 32'(alu_to_accumulator_xfer), 32'(exp_x));
    tick();
    check({tag, " valid_drop"}, 32'(result_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 4'd0; decimal = 1'b0;
    a_in = 8'h00; b_in = 8'h00; carry_in = 1'b0;
    tick();
    tick();
    check("reset alu_out", 32'(alu_out), 32'h00);
    check("reset flags", 32'({n_out, v_out, z_out, c_out}), 32'h0);
    check("reset status", 32'({busy, result_valid, alu_to_accumulator_xfer}), 32'h0);
    reset = 1'b0;
    tick();

    run_op("adc_bin",   OP_ADC, 1'b0, 8'h50, 8'h50, 1'b0, 2, 8'hA0, 4'b1100, 4'hF, 1'b1);
    run_op("adc_dec",   OP_ADC, 1'b1, 8'h58, 8'h46, 1'b1, 3, 8'h05, 4'b0101, 4'hF, 1'b1);
    run_op("sbc_dec",   OP_SBC, 1'b1, 8'h12, 8'h21, 1'b1, 3, 8'h91, 4'b1000, 4'hF, 1'b1);
    run_op("cmp_eq",    OP_CMP, 1'b0, 8'h40, 8'h40, 1'b0, 2, 8'h00, 4'b0011, 4'hF, 1'b0);
    run_op("inc_wrap",  OP_INC, 1'b0, 8'hFF, 8'h00, 1'b1, 2, 8'h00, 4'b0011, 4'hF, 1'b1);
    run_op("dec_wrap",  OP_DEC, 1'b0, 8'h00, 8'h00, 1'b0, 2, 8'hFF, 4'b1000, 4'hF, 1'b1);
    run_op("sbc_bin",   OP_SBC, 1'b0, 8'h50, 8'h30, 1'b1, 2, 8'h20, 4'b0001, 4'hF, 1'b1);
    run_op("adc_dec99", OP_ADC, 1'b1, 8'h99, 8'h01, 1'b0, 3, 8'h00, 4'b0011, 4'hF, 1'b1);
    run_op("asl",       OP_ASL, 1'b0, 8'h81, 8'h00, 1'b0, 2, 8'h02, 4'b0001, 4'hF, 1'b1);
    run_op("lsr",       OP_LSR, 1'b0, 8'h01, 8'h00, 1'b0, 2, 8'h00, 4'b0011, 4'hF, 1'b1);
    run_op("rol",       OP_ROL, 1'b0, 8'h80, 8'h00, 1'b1, 2, 8'h01, 4'b0001, 4'hF, 1'b1);
    run_op("bit",       OP_BIT, 1'b0, 8'h0F, 8'hC0, 1'b0, 2, 8'h0F, 4'b1110, 4'hF, 1'b0);
    run_op("and",       OP_AND, 1'b0, 8'hF0, 8'h0F, 1'b1, 2, 8'h00, 4'b0011, 4'hF, 1'b1);
    run_op("eor_dflag", OP_EOR, 1'b1, 8'hFF, 8'h0F, 1'b0, 2, 8'hF0, 4'b1000, 4'hF, 1'b1);
    run_op("undef_op",  4'hF,   1'b0, 8'h5A, 8'h33, 1'b1, 2, 8'h5A, 4'b0001, 4'b0101, 1'b0);

    // Second start while busy must be dropped.
    issue(OP_ROR, 1'b0, 8'h01, 8'h00, 1'b1);
    op = OP_ADC; a_in = 8'h33; b_in = 8'h44; carry_in = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_ign valid", 32'(result_valid), 32'd1);
    check("busy_ign alu_out", 32'(alu_out), 32'h80);
    check("busy_ign nzc", 32'({n_out, z_out, c_out}), 32'b101);
    pulses = 1;
    repeat (6) begin
      tick();
      if (result_valid) pulses++;
    end
    check("busy_ign pulses", 32'(pulses), 32'd1);
    check("busy_ign held", 32'(alu_out), 32'h80);

    // Reset while in DADJ discards the result.
    issue(OP_ADC, 1'b1, 8'h58, 8'h46, 1'b1);
    tick();
    check("rst_dadj pre busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_dadj alu_out", 32'(alu_out), 32'h00);
    check("rst_dadj status", 32'({busy, result_valid, alu_to_accumulator_xfer}), 32'h0);
    pulses = 0;
    repeat (4) begin
      tick();
      if (result_valid) pulses++;
    end
    check("rst_dadj pulses", 32'(pulses), 32'd0);
    run_op("after_rst", OP_ADC, 1'b1, 8'h19, 8'h01, 1'b0, 3, 8'h20, 4'b0000, 4'hF, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
